// File: rtl/fdd_wr_capture.sv
// Floppy write-direction capture: frames sync/mark/256 words/CRC and buffers one good sector.
// Optional CRC checking is enabled by defining FDD_WR_CRC_EN.
module fdd_wr_capture #(
   parameter logic [15:0] SYNC_WORD = 16'hA1A1,
   parameter logic [15:0] MARK_WORD = 16'hA1FB,
   parameter int          SEC_WORDS = 256
) (
   input  logic        pin_25mhz_ck,
   input  logic        ppu_vm_init_i,
   input  logic        wr_gate,
   input  logic        wr_strobe,
   input  logic [15:0] data_in,
   input  logic [31:0] sd_lba_i,
   input  logic [7:0]  buf_rd_addr,
   output logic [15:0] buf_rd_data,
   output logic        sec_rdy,
   output logic [31:0] sec_lba,
   input  logic        sd_done,
   output logic        crc_err,
   output logic        overrun
);

   typedef enum logic [2:0] {IDLE, HUNT, MARK, DATA, CRCW, CHECK} state_t;

   localparam logic [7:0] LAST = 8'(SEC_WORDS - 1);

   state_t      state, state_nx;
   logic [7:0]  cnt;
   logic [31:0] lba_shadow;
   logic [15:0] mem [0:SEC_WORDS-1];
   logic        take, crc_pass;
   logic        lba_ld, wr_en, crc_chk, rdy_set, crc_err_nx, ovr_nx;

   assign take = wr_strobe & wr_gate;

   always_ff @(posedge pin_25mhz_ck or posedge ppu_vm_init_i)
      if (ppu_vm_init_i) state <= IDLE;
      else               state <= state_nx;

   always_comb begin
      state_nx   = state;
      lba_ld     = 1'b0;
      wr_en      = 1'b0;
      crc_chk    = 1'b0;
      rdy_set    = 1'b0;
      crc_err_nx = 1'b0;
      ovr_nx     = 1'b0;
      if (!wr_gate) state_nx = IDLE;
      else begin
         case (state)
            IDLE: state_nx = HUNT;
            HUNT: if (take && data_in == SYNC_WORD) state_nx = MARK;
            MARK: if (take) begin
               if (data_in == MARK_WORD) begin
                  // A buffered sector is never overwritten: report and re-hunt.
                  if (sec_rdy) begin
                     ovr_nx   = 1'b1;
                     state_nx = HUNT;
                  end else begin
                     lba_ld   = 1'b1;
                     state_nx = DATA;
                  end
               end else if (data_in != SYNC_WORD) state_nx = HUNT;
            end
            DATA: if (take) begin
               wr_en = 1'b1;
               if (cnt == LAST) state_nx = CRCW;
            end
            CRCW: if (take) begin
               crc_chk  = 1'b1;
               state_nx = CHECK;
            end
            CHECK: begin
               if (crc_pass) rdy_set    = 1'b1;
               else          crc_err_nx = 1'b1;
               state_nx = HUNT;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge pin_25mhz_ck or posedge ppu_vm_init_i)
      if (ppu_vm_init_i) begin
         cnt        <= '0;
         lba_shadow <= '0;
         sec_rdy    <= 1'b0;
         sec_lba    <= '0;
         crc_err    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (lba_ld) begin
            cnt        <= '0;
            lba_shadow <= sd_lba_i;
         end else if (wr_en) cnt <= cnt + 8'd1;
         // A new sector outranks a simultaneous sd_done.
         if (rdy_set) begin
            sec_rdy <= 1'b1;
            sec_lba <= lba_shadow;
         end else if (sd_done) sec_rdy <= 1'b0;
         crc_err <= crc_err_nx;
         overrun <= ovr_nx;
      end

   always_ff @(posedge pin_25mhz_ck)
      if (wr_en) mem[cnt] <= data_in;

   always_ff @(posedge pin_25mhz_ck or posedge ppu_vm_init_i)
      if (ppu_vm_init_i) buf_rd_data <= '0;
      else               buf_rd_data <= mem[buf_rd_addr];

`ifdef FDD_WR_CRC_EN
   // CRC-16/CCITT over one word, high byte first, MSB first.
   function automatic logic [15:0] crc_word(input logic [15:0] c_in, input logic [15:0] w);
      logic [15:0] c;
      c = c_in;
      for (int i = 15; i >= 0; i--)
         c = {c[14:0], 1'b0} ^ ((c[15] ^ w[i]) ? 16'h1021 : 16'h0000);
      return c;
   endfunction

   localparam logic [15:0] CRC_MARK = crc_word(crc_word(16'hFFFF, SYNC_WORD), MARK_WORD);

   logic [15:0] crc;
   logic        crc_ok;

   always_ff @(posedge pin_25mhz_ck or posedge ppu_vm_init_i)
      if (ppu_vm_init_i) begin
         crc    <= 16'hFFFF;
         crc_ok <= 1'b0;
      end else begin
         if (lba_ld)       crc <= CRC_MARK;
         else if (wr_en)   crc <= crc_word(crc, data_in);
         if (crc_chk)      crc_ok <= (data_in == crc);
      end

   assign crc_pass = crc_ok;
`else
   assign crc_pass = 1'b1;
`endif

endmodule

// File: tb/tb_fdd_wr_capture.sv
// Directed bench for fdd_wr_capture: framing, CRC, abort, overrun, re-sync and async reset.
module tb_fdd_wr_capture;
   logic        clk = 1'b0, rst = 1'b1;
   logic        wr_gate = 1'b0, wr_strobe = 1'b0, sd_done = 1'b0;
   logic [15:0] data_in = '0;
   logic [31:0] sd_lba_i = '0;
   logic [7:0]  buf_rd_addr = '0;
   logic [15:0] buf_rd_data;
   logic        sec_rdy, crc_err, overrun;
   logic [31:0] sec_lba;
   int          total = 0, fails = 0;
   logic        ovr_seen;

   always #5 clk = ~clk;

   fdd_wr_capture dut (
      .pin_25mhz_ck(clk), .ppu_vm_init_i(rst), .wr_gate(wr_gate), .wr_strobe(wr_strobe),
      .data_in(data_in), .sd_lba_i(sd_lba_i), .buf_rd_addr(buf_rd_addr),
      .buf_rd_data(buf_rd_data), .sec_rdy(sec_rdy), .sec_lba(sec_lba), .sd_done(sd_done),
      .crc_err(crc_err), .overrun(overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ b[i]) c = (c << 1) ^ 16'h1021;
         else              c = c << 1;
      end
      return c;
   endfunction

   function automatic logic [15:0] body_crc(input logic [15:0] pat);
      logic [15:0] c, w;
      c = 16'hFFFF;
      c = crc_byte(c, 8'hA1); c = crc_byte(c, 8'hA1);
      c = crc_byte(c, 8'hA1); c = crc_byte(c, 8'hFB);
      for (int i = 0; i < 256; i++) begin
         w = 16'(i) ^ pat;
         c = crc_byte(c, w[15:8]);
         c = crc_byte(c, w[7:0]);
      end
      return c;
   endfunction

   // Returns at the negedge following the consuming posedge.
   task automatic send_word(input logic [15:0] w);
      @(negedge clk); data_in = w; wr_strobe = 1'b1;
      @(negedge clk); wr_strobe = 1'b0;
   endtask

   task automatic send_data(input int first, input int last, input logic [15:0] pat);
      for (int i = first; i <= last; i++) send_word(16'(i) ^ pat);
   endtask

   task automatic send_frame(input logic [31:0] lba, input logic [15:0] pat, input logic [15:0] cx);
      sd_lba_i = lba;
      send_word(16'hA1A1);
      send_word(16'hA1FB);
      ovr_seen = overrun;
      send_data(0, 255, pat);
      send_word(body_crc(pat) ^ cx);
      @(negedge clk);   // CHECK cycle result visible here
   endtask

   task automatic read_buf(input logic [7:0] a, input logic [15:0] exp, input string tag);
      @(negedge clk); buf_rd_addr = a;
      @(negedge clk); check(tag, buf_rd_data, exp);
   endtask

   task automatic pulse_done();
      @(negedge clk); sd_done = 1'b1;
      @(negedge clk); sd_done = 1'b0;
   endtask

   initial begin
      // reset state
      #12;
      check("rst_sec_rdy", sec_rdy, 0);
      check("rst_sec_lba", sec_lba, 0);
      check("rst_crc_err", crc_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_buf_rd", buf_rd_data, 0);
      @(negedge clk); rst = 1'b0; wr_gate = 1'b1;
      @(negedge clk);

      // T1: good frame
      send_frame(32'd1234, 16'h0000, 16'h0000);
      check("t1_sec_rdy", sec_rdy, 1);
      check("t1_sec_lba", sec_lba, 32'd1234);
      check("t1_crc_err", crc_err, 0);
      read_buf(8'h10, 16'h0010, "t1_buf10");
      read_buf(8'hFF, 16'h00FF, "t1_bufff");
      pulse_done();
      check("t1_done_clr", sec_rdy, 0);

      // T2: corrupted CRC
      send_frame(32'd77, 16'h0000, 16'h0001);
`ifdef FDD_WR_CRC_EN
      check("t2_crc_err", crc_err, 1);
      check("t2_sec_rdy", sec_rdy, 0);
`else
      check("t2_crc_err", crc_err, 0);
      check("t2_sec_rdy", sec_rdy, 1);
      check("t2_sec_lba", sec_lba, 32'd77);
`endif
      @(negedge clk);
      check("t2_crc_err_pulse", crc_err, 0);
      pulse_done();
      check("t2_clr", sec_rdy, 0);

      // T3: gate drops mid-sector
      sd_lba_i = 32'd9;
      send_word(16'hA1A1); send_word(16'hA1FB);
      send_data(0, 99, 16'h5000);
      @(negedge clk); wr_gate = 1'b0;
      send_word(16'hA1A1);
      @(negedge clk); wr_gate = 1'b1;
      @(negedge clk);
      check("t3_no_rdy", sec_rdy, 0);
      check("t3_no_err", crc_err, 0);
      send_frame(32'd555, 16'h0000, 16'h0000);
      check("t3_rdy", sec_rdy, 1);
      check("t3_lba", sec_lba, 32'd555);
      read_buf(8'h05, 16'h0005, "t3_buf05");

      // T4: second frame while buffer full
      send_frame(32'd999, 16'h0F00, 16'h0000);
      check("t4_ovr_seen", ovr_seen, 1);
      check("t4_ovr_pulse", overrun, 0);
      check("t4_rdy_held", sec_rdy, 1);
      check("t4_lba_held", sec_lba, 32'd555);
      read_buf(8'h10, 16'h0010, "t4_buf_held");
      pulse_done();
      check("t4_done_clr", sec_rdy, 0);
      pulse_done();
      check("t4_done_idle", sec_rdy, 0);

      // T5: repeated sync then mark locks; sync then junk does not
      sd_lba_i = 32'd42;
      send_word(16'hA1A1); send_word(16'hA1A1); send_word(16'hA1A1); send_word(16'hA1FB);
      send_data(0, 255, 16'h0000);
      send_word(body_crc(16'h0000));
      @(negedge clk);
      check("t5_lock_rdy", sec_rdy, 1);
      check("t5_lock_lba", sec_lba, 32'd42);
      pulse_done();
      sd_lba_i = 32'd43;
      send_word(16'hA1A1); send_word(16'h1234); send_word(16'hA1FB);
      send_data(0, 255, 16'h0000);
      send_word(body_crc(16'h0000));
      @(negedge clk);
      check("t5_nolock_rdy", sec_rdy, 0);
      check("t5_nolock_err", crc_err, 0);

      // T6: async reset at data word 50
      sd_lba_i = 32'hDEAD;
      send_word(16'hA1A1); send_word(16'hA1FB);
      send_data(0, 49, 16'h0000);
      buf_rd_addr = 8'h10;
      @(negedge clk);
      check("t6_pre_rd", buf_rd_data, 16'h0010);
      #2 rst = 1'b1;
      #1;
      check("t6_async_rd", buf_rd_data, 0);
      check("t6_async_rdy", sec_rdy, 0);
      check("t6_async_lba", sec_lba, 0);
      @(negedge clk); rst = 1'b0;
      send_data(50, 255, 16'h0000);
      send_word(body_crc(16'h0000));
      @(negedge clk);
      check("t6_lost", sec_rdy, 0);
      send_frame(32'hDEAD, 16'h0000, 16'h0000);
      check("t6_recover_rdy", sec_rdy, 1);
      check("t6_recover_lba", sec_lba, 32'hDEAD);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
